// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side end of the MEM-stage load/store interface. Accepts one request
//   at a time, performs a byte/half/word access on an internal little-endian
//   word array and answers after LATENCY cycles, stalling the pipeline while
//   the request is outstanding.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words in the array (power of 2)
//   LATENCY     : cycles from acceptance to response (>= 1)
//
// Ports
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous, active-low reset
//   ReqValid   in   MEM stage holds a load/store
//   ReqWrite   in   1 = store, 0 = load
//   ReqAddr    in   byte address [31:0]
//   ReqWData   in   right-aligned store data [31:0]
//   ReqSize    in   00 byte, 01 half, 10 word, 11 reserved
//   ReqSigned  in   sign-extend byte/half load results
//   ReqReady   out  responder idle, request accepted on ReqValid & ReqReady
//   Stall      out  pipeline freeze request
//   RspValid   out  one-cycle response pulse
//   RspRData   out  load result, held until the next load/error response
//   AddrError  out  access rejected (qualified by RspValid)
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        ReqValid,
   input  logic        ReqWrite,
   input  logic [31:0] ReqAddr,
   input  logic [31:0] ReqWData,
   input  logic [1:0]  ReqSize,
   input  logic        ReqSigned,
   output logic        ReqReady,
   output logic        Stall,
   output logic        RspValid,
   output logic [31:0] RspRData,
   output logic        AddrError
);

   localparam int ADDR_BITS = $clog2(DEPTH_WORDS);
   localparam int CNT_W     = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              commit;

   // Latched request
   logic              lat_write;
   logic [31:0]       lat_addr;
   logic [31:0]       lat_wdata;
   logic [1:0]        lat_size;
   logic              lat_signed;

   // Request seen by the commit logic. With LATENCY=1 the commit edge is the
   // acceptance edge, so the live inputs are used while still in IDLE.
   logic              cur_write;
   logic [31:0]       cur_addr;
   logic [31:0]       cur_wdata;
   logic [1:0]        cur_size;
   logic              cur_signed;

   logic              err;
   logic [ADDR_BITS-1:0] word_idx;
   logic [3:0]        lane_en;
   logic [31:0]       wdata_rep;
   logic              we, re;
   logic [31:0]       mem_q;

   // Response bookkeeping
   logic              err_reg;
   logic              data_ok_reg;
   logic [1:0]        rd_size_reg;
   logic              rd_signed_reg;
   logic [1:0]        rd_lane_reg;
   logic [31:0]       ext_data;

   //----------------------------------------------------------------------
   // FSM
   //----------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      commit     = 1'b0;
      ReqReady   = 1'b0;
      RspValid   = 1'b0;
      Stall      = 1'b0;
      case (state_reg)
         S_IDLE: begin
            ReqReady = 1'b1;
            Stall    = ReqValid;
            if (ReqValid) begin
               if (LATENCY == 1) begin
                  state_next = S_RESP;
                  commit     = 1'b1;
               end else begin
                  state_next = S_BUSY;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         S_BUSY: begin
            Stall = 1'b1;
            if (cnt_reg == '0) begin
               state_next = S_RESP;
               commit     = 1'b1;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         S_RESP: begin
            RspValid   = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      // Stall must drop as soon as reset asserts, even with ReqValid high.
      Stall = Stall & Reset;
   end

   //----------------------------------------------------------------------
   // Request latch
   //----------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_size   <= '0;
         lat_signed <= 1'b0;
      end else if (state_reg == S_IDLE && ReqValid) begin
         lat_write  <= ReqWrite;
         lat_addr   <= ReqAddr;
         lat_wdata  <= ReqWData;
         lat_size   <= ReqSize;
         lat_signed <= ReqSigned;
      end
   end

   always_comb begin
      if (state_reg == S_IDLE) begin
         cur_write  = ReqWrite;
         cur_addr   = ReqAddr;
         cur_wdata  = ReqWData;
         cur_size   = ReqSize;
         cur_signed = ReqSigned;
      end else begin
         cur_write  = lat_write;
         cur_addr   = lat_addr;
         cur_wdata  = lat_wdata;
         cur_size   = lat_size;
         cur_signed = lat_signed;
      end
   end

   //----------------------------------------------------------------------
   // Address checks, lane enables, store data replication
   //----------------------------------------------------------------------
   always_comb begin
      err = 1'b0;
      case (cur_size)
         2'b01:   err = cur_addr[0];
         2'b10:   err = |cur_addr[1:0];
         2'b11:   err = 1'b1;
         default: err = 1'b0;
      endcase
      if ((cur_addr >> (ADDR_BITS + 2)) != 32'd0)
         err = 1'b1;
   end

   assign word_idx = cur_addr[ADDR_BITS+1:2];

   always_comb begin
      case (cur_size)
         2'b00: begin
            lane_en   = 4'b0001 << cur_addr[1:0];
            wdata_rep = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            lane_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{cur_wdata[15:0]}};
         end
         default: begin
            lane_en   = 4'b1111;
            wdata_rep = cur_wdata;
         end
      endcase
   end

   assign we = commit & cur_write & ~err;
   assign re = commit & ~cur_write & ~err;

   //----------------------------------------------------------------------
   // Storage: one byte-wide array per lane, registered read into mem_q.
   // Not reset; contents survive Reset.
   //----------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH_WORDS];
         logic [7:0] lane_q;

         always_ff @(posedge Clk) begin
            if (we && lane_en[gi])
               lane_mem[word_idx] <= wdata_rep[gi*8 +: 8];
            if (re)
               lane_q <= lane_mem[word_idx];
         end

         assign mem_q[gi*8 +: 8] = lane_q;
      end
   endgenerate

   //----------------------------------------------------------------------
   // Response state. mem_q is only refreshed by good loads, so RspRData is
   // rebuilt from it with the size/sign/lane of the last load; an error
   // response (load or store) forces zero. Stores leave this untouched.
   //----------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         err_reg       <= 1'b0;
         data_ok_reg   <= 1'b0;
         rd_size_reg   <= '0;
         rd_signed_reg <= 1'b0;
         rd_lane_reg   <= '0;
      end else if (commit) begin
         err_reg <= err;
         if (!cur_write || err) begin
            data_ok_reg   <= ~err;
            rd_size_reg   <= cur_size;
            rd_signed_reg <= cur_signed;
            rd_lane_reg   <= cur_addr[1:0];
         end
      end
   end

   always_comb begin
      logic [7:0]  b;
      logic [15:0] h;
      b = mem_q[{rd_lane_reg, 3'b000} +: 8];
      h = rd_lane_reg[1] ? mem_q[31:16] : mem_q[15:0];
      case (rd_size_reg)
         2'b00:   ext_data = {{24{rd_signed_reg & b[7]}}, b};
         2'b01:   ext_data = {{16{rd_signed_reg & h[15]}}, h};
         default: ext_data = mem_q;
      endcase
   end

   assign RspRData  = data_ok_reg ? ext_data : 32'd0;
   assign AddrError = (state_reg == S_RESP) & err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Two instances share the clock,
//   reset and request fields: u_a with LATENCY=2, u_b with LATENCY=1, each
//   with its own ReqValid.
module tb_data_mem_responder;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        valid_a, valid_b;
   logic        ReqWrite;
   logic [31:0] ReqAddr;
   logic [31:0] ReqWData;
   logic [1:0]  ReqSize;
   logic        ReqSigned;

   logic        a_rdy, a_stall, a_rv, a_err;
   logic [31:0] a_rdata;
   logic        b_rdy, b_stall, b_rv, b_err;
   logic [31:0] b_rdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Results of the last do_req
   int          r_lat, r_stall, r_cyc;
   logic [31:0] r_data;
   logic        r_err, r_rsp_stall;

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_a (
      .Clk(Clk), .Reset(Reset), .ReqValid(valid_a), .ReqWrite(ReqWrite),
      .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqSize(ReqSize),
      .ReqSigned(ReqSigned), .ReqReady(a_rdy), .Stall(a_stall),
      .RspValid(a_rv), .RspRData(a_rdata), .AddrError(a_err)
   );

   data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_b (
      .Clk(Clk), .Reset(Reset), .ReqValid(valid_b), .ReqWrite(ReqWrite),
      .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqSize(ReqSize),
      .ReqSigned(ReqSigned), .ReqReady(b_rdy), .Stall(b_stall),
      .RspValid(b_rv), .RspRData(b_rdata), .AddrError(b_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request on u_a (sel=0) or u_b (sel=1), starting just after a
   // rising edge. Samples on falling edges until RspValid, then drops ReqValid
   // just after the edge that leaves RESP.
   task do_req(input bit sel, input bit wr, input logic [31:0] addr,
               input logic [31:0] wdata, input logic [1:0] size, input bit sgn);
      ReqWrite  = wr;
      ReqAddr   = addr;
      ReqWData  = wdata;
      ReqSize   = size;
      ReqSigned = sgn;
      if (sel) valid_b = 1'b1; else valid_a = 1'b1;
      r_lat   = 0;
      r_stall = 0;
      forever begin
         @(negedge Clk);
         if (sel ? b_rv : a_rv) break;
         if (sel ? b_stall : a_stall) r_stall++;
         if (r_lat >= 20) break;
         @(posedge Clk);
         #1;
         r_lat++;
      end
      r_data      = sel ? b_rdata : a_rdata;
      r_err       = sel ? b_err : a_err;
      r_rsp_stall = sel ? b_stall : a_stall;
      r_cyc       = cyc;
      @(posedge Clk);
      #1;
      valid_a = 1'b0;
      valid_b = 1'b0;
      $display("txn dut=%0d wr=%0d addr=%h wdata=%h size=%0d sgn=%0d -> lat=%0d stall=%0d rdata=%h err=%0d",
               sel, wr, addr, wdata, size, sgn, r_lat, r_stall, r_data, r_err);
   endtask

   int pulses, first_c, second_c, rv_seen, t0;

   initial begin
      Reset = 1'b0;
      valid_a = 1'b1;   // held during reset: Stall must stay low
      valid_b = 1'b0;
      ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0; ReqSize = 2'b10; ReqSigned = 1'b0;

      // ---- reset values
      @(negedge Clk);
      chk("rst_ready", a_rdy, 1);
      chk("rst_stall", a_stall, 0);
      chk("rst_rspvalid", a_rv, 0);
      chk("rst_rdata", a_rdata, 0);
      chk("rst_adderr", a_err, 0);
      @(posedge Clk); #1;
      valid_a = 1'b0;
      Reset = 1'b1;

      // ---- word store / load, LATENCY=2
      do_req(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0);
      chk("sw_latency", r_lat, 2);
      chk("sw_stall_cycles", r_stall, 2);
      chk("sw_err", r_err, 0);
      chk("sw_stall_in_resp", r_rsp_stall, 0);
      do_req(0, 0, 32'h10, 0, 2'b10, 0);
      chk("lw_latency", r_lat, 2);
      chk("lw_data", r_data, 32'hDEADBEEF);
      chk("lw_err", r_err, 0);

      // ---- sub-word
      do_req(0, 1, 32'h10, 32'h11223344, 2'b10, 0);
      do_req(0, 1, 32'h13, 32'h00000080, 2'b00, 0);
      do_req(0, 0, 32'h10, 0, 2'b10, 0);
      chk("sb_merge", r_data, 32'h80223344);
      do_req(0, 0, 32'h13, 0, 2'b00, 1);
      chk("lb_signed", r_data, 32'hFFFFFF80);
      do_req(0, 0, 32'h13, 0, 2'b00, 0);
      chk("lbu", r_data, 32'h00000080);
      do_req(0, 0, 32'h12, 0, 2'b01, 1);
      chk("lh_signed", r_data, 32'hFFFF8022);
      do_req(0, 0, 32'h10, 0, 2'b01, 0);
      chk("lhu_low", r_data, 32'h00003344);
      do_req(0, 1, 32'h30, 32'h55667788, 2'b10, 0);
      chk("store_keeps_rdata", r_data, 32'h00003344);

      // ---- errors
      do_req(0, 0, 32'h12, 0, 2'b10, 0);
      chk("lw_misaligned_err", r_err, 1);
      chk("lw_misaligned_data", r_data, 0);
      do_req(0, 1, 32'h11, 32'h0000BEEF, 2'b01, 0);
      chk("sh_misaligned_err", r_err, 1);
      do_req(0, 0, 32'h10, 0, 2'b10, 0);
      chk("mem_unchanged", r_data, 32'h80223344);
      chk("mem_unchanged_err", r_err, 0);
      do_req(0, 0, 32'h1000, 0, 2'b10, 0);
      chk("oob_err", r_err, 1);
      chk("oob_data", r_data, 0);
      do_req(0, 0, 32'h10, 0, 2'b11, 0);
      chk("size11_err", r_err, 1);

      // ---- reset in the middle of a store
      do_req(0, 1, 32'h20, 32'h12345678, 2'b10, 0);
      do_req(0, 0, 32'h20, 0, 2'b10, 0);
      chk("pre_reset_load", r_data, 32'h12345678);
      ReqWrite = 1'b1; ReqAddr = 32'h20; ReqWData = 32'hAAAA5555; ReqSize = 2'b10;
      valid_a = 1'b1;
      @(posedge Clk); #1;          // now BUSY
      chk("busy_stall", a_stall, 1);
      #2 Reset = 1'b0;
      #1;
      chk("mid_rst_rspvalid", a_rv, 0);
      chk("mid_rst_stall", a_stall, 0);
      chk("mid_rst_ready", a_rdy, 1);
      chk("mid_rst_rdata", a_rdata, 0);
      chk("mid_rst_adderr", a_err, 0);
      valid_a = 1'b0;
      rv_seen = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge Clk); if (a_rv) rv_seen++;
      end
      @(posedge Clk); #1;
      Reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk); if (a_rv) rv_seen++;
      end
      chk("no_rsp_after_reset", rv_seen, 0);
      @(posedge Clk); #1;
      do_req(0, 0, 32'h20, 0, 2'b10, 0);
      chk("store_dropped_by_reset", r_data, 32'h12345678);

      // ---- held request: valid through RESP plus one cycle
      ReqWrite = 1'b0; ReqAddr = 32'h10; ReqSize = 2'b10; ReqSigned = 1'b0;
      valid_a = 1'b1;
      pulses = 0; first_c = -1; second_c = -1;
      for (int c = 0; c < 10; c++) begin
         @(negedge Clk);
         if (c == 2) chk("held_ready_in_resp", a_rdy, 0);
         if (c == 3) chk("held_stall_after_resp", a_stall, 1);
         if (a_rv) begin
            pulses++;
            if (first_c < 0) first_c = c; else second_c = c;
         end
         @(posedge Clk); #1;
         if (c == 3) valid_a = 1'b0;
      end
      $display("txn held: pulses=%0d first=%0d second=%0d", pulses, first_c, second_c);
      chk("held_pulses", pulses, 2);
      chk("held_first_rsp", first_c, 2);
      chk("held_second_rsp", second_c, 5);
      chk("held_data", a_rdata, 32'h80223344);

      // ---- LATENCY=1
      do_req(1, 1, 32'h40, 32'hCAFEF00D, 2'b10, 0);
      chk("l1_latency", r_lat, 1);
      chk("l1_stall_cycles", r_stall, 1);
      do_req(1, 0, 32'h40, 0, 2'b10, 0);
      chk("l1_load", r_data, 32'hCAFEF00D);
      t0 = cyc;
      do_req(1, 1, 32'h44, 32'h01020304, 2'b10, 0);
      do_req(1, 0, 32'h44, 0, 2'b10, 0);
      chk("l1_seq_lw", r_data, 32'h01020304);
      do_req(1, 1, 32'h45, 32'h000000FF, 2'b00, 0);
      do_req(1, 0, 32'h44, 0, 2'b01, 1);
      chk("l1_seq_lh_signed", r_data, 32'hFFFFFF04);
      chk("l1_seq_cycles", r_cyc - t0 + 1, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder: the memory-side end of the MEM-stage load/store interface of the 5-stage pipeline. It accepts one request at a time from the MEM stage and performs byte, halfword or word access on an internal little-endian word array. It returns read data or a write acknowledge after a fixed latency, and drives `Stall` so the pipeline freezes while a request is outstanding.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the array. Must be a power of 2. `ADDR_BITS = log2(DEPTH_WORDS)`.
- `LATENCY`, default 2: number of cycles from request acceptance to response. Must be ≥1.
- `Clk` in 1: the single clock. All state updates on its rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `ReqValid` in 1: the MEM stage holds a load or store. Held stable until the response cycle.
- `ReqWrite` in 1: 1 = store, 0 = load.
- `ReqAddr` in 32: byte address.
- `ReqWData` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `ReqSize` in 2: access size. 00 byte, 01 half, 10 word, 11 reserved.
- `ReqSigned` in 1: on loads, 1 = sign-extend and 0 = zero-extend byte/half results.
- `ReqReady` out 1: high in IDLE; the request is accepted on an edge where `ReqValid & ReqReady`.
- `Stall` out 1: pipeline freeze request.
- `RspValid` out 1: one-cycle response pulse.
- `RspRData` out 32: load result. Holds its value until the next response.
- `AddrError` out 1: valid only with `RspValid`. The access was rejected.

## Operation
- States:
  - IDLE: `ReqReady`=1.
  - BUSY: a wait counter is running.
  - RESP: `RspValid`=1.
- Transitions:
  - IDLE → BUSY on acceptance if `LATENCY`>1. The request is latched and the counter is loaded with `LATENCY`-2.
  - IDLE → RESP on acceptance if `LATENCY`=1.
  - BUSY → RESP when the counter reaches 0; otherwise the counter decrements.
  - RESP → IDLE unconditionally. A request still visible during RESP is never re-accepted.
- All request fields are latched at acceptance. Input changes after acceptance are ignored.
- Word index = `ReqAddr[ADDR_BITS+1:2]`. Byte lane = `ReqAddr[1:0]`. Little-endian: byte 0 is bits [7:0].
- Error checks are evaluated on the latched request. Any of the following sets `AddrError`:
  - Size 11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - `ReqAddr` ≥ 4·`DEPTH_WORDS`.
- Error behaviour: no array write, `RspRData` = 0, `AddrError`=1 during RESP.
- Store commit happens on the edge entering RESP. Only the addressed lanes are written: byte → 1 lane, half → lanes {1,0} or {3,2}, word → all 4 lanes.
- Load data is captured on the same edge into `RspRData`, then extended per `ReqSigned`.
- A store response leaves `RspRData` unchanged.
- Array contents are not affected by reset and are X until written.
- `Stall` = (IDLE & `ReqValid`) | BUSY. It is low in RESP, so the pipeline advances at the end of the response cycle.

## Timing
- Request accepted at the end of cycle N. `RspValid` is high in exactly cycle N+`LATENCY`. `Stall` is high for cycles N..N+`LATENCY`-1.
- Back-to-back requests: the next acceptance is possible at the end of cycle N+`LATENCY`+1, so the throughput is 1 per `LATENCY`+1 cycles.
- Read-after-write: a load accepted after a store's RESP sees the stored data.
- While `Reset`=0 (asynchronous, mid-operation included):
  - State returns to IDLE and the counter goes to 0.
  - The latched request is discarded; a store not yet committed is never written.
  - `RspValid`=0, `RspRData`=0, `AddrError`=0, `Stall`=0, `ReqReady`=1.
- First acceptance is possible on the first rising edge after `Reset` rises.
- `ReqValid`=0 in IDLE: no state change, `Stall`=0.

## Test plan
- Word store then load, `LATENCY`=2:
  - Store 0xDEADBEEF @0x10. `Stall` is high 2 cycles and `RspValid` pulses in cycle 2 with `AddrError`=0.
  - Load @0x10 accepted 1 cycle later returns 0xDEADBEEF with `RspValid` 2 cycles after acceptance.
- Sub-word stores and loads:
  - `sb` 0x80 @0x13 over 0x11223344 gives word 0x80223344.
  - `lb` signed @0x13 returns 0xFFFFFF80; unsigned returns 0x00000080.
  - `lh` signed @0x12 returns 0xFFFF8022.
- Errors:
  - Word load @0x12 → `AddrError`=1, `RspRData`=0.
  - Half store @0x11 → `AddrError`=1 and memory unchanged.
  - Load @0x1000 with `DEPTH_WORDS`=1024 → `AddrError`=1.
- Reset mid-store:
  - Store 0xAAAA5555 @0x20, then assert `Reset` in the BUSY cycle.
  - Outputs go to reset values immediately and no `RspValid` appears.
  - A later load @0x20 returns the prior value.
- Held request: `ReqValid` kept high through RESP and one extra cycle yields exactly two responses, with the second acceptance in the cycle after RESP.
- `LATENCY`=1: `Stall` is high for 1 cycle and `RspValid` follows in the next cycle. A 4-request sequence completes in 8 cycles.
